board_reset_sequencer: RTL

- Board-level reset and bring-up sequencer that replaces the hardwired global reset and constant LED pattern in board tops.
- Debounces PCIe PERST (npor) and sequences per-channel memory-interface resets across NUM_MEM channels (DDR3/QDRII).
- Waits for calibration with timeout and retry, then releases the kernel reset.
- Drives status LEDs. Sits between board pins and the system instance.

---
 rtl/board_reset_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/board_reset_sequencer.sv
// Board bring-up sequencer: debounces PCIe PERST, sequences per-channel memory
// resets through calibration with timeout/retry, then releases the kernel reset.
module board_reset_sequencer #(
    parameter int unsigned NUM_MEM         = 4,
    parameter int unsigned LED_WIDTH       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES     = 256,
    parameter int unsigned CAL_TIMEOUT     = 1 << 20,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned HB_BITS         = 24,
    localparam int unsigned RETRY_W        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pcie_npor,
    input  logic [NUM_MEM-1:0]   mem_enable_mask,
    input  logic [NUM_MEM-1:0]   mem_cal_success,
    input  logic [NUM_MEM-1:0]   mem_cal_fail,
    output logic [NUM_MEM-1:0]   mem_reset_n,
    output logic                 kernel_reset_n,
    output logic                 sys_ready,
    output logic                 cal_error,
    output logic [RETRY_W-1:0]   retry_count,
    output logic [2:0]           state,
    output logic [LED_WIDTH-1:0] leds
);

    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned CAL_W  = (CAL_TIMEOUT > 1) ? $clog2(CAL_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_RESET_HOLD     = 3'd0,
        ST_MEM_RESET      = 3'd1,
        ST_CAL_WAIT       = 3'd2,
        ST_KERNEL_RELEASE = 3'd3,
        ST_RUN            = 3'd4,
        ST_ERROR          = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic                 npor_meta_q, npor_s_q;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CAL_W-1:0]     cal_cnt_q, cal_cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [HB_BITS-1:0]   hb_cnt_q, hb_cnt_d;
    logic                 hb_q, hb_d;
    logic [NUM_MEM-1:0]   mem_reset_n_q, mem_reset_n_d;
    logic                 kernel_reset_n_q, kernel_reset_n_d;
    logic                 sys_ready_q, sys_ready_d;
    logic                 cal_error_q, cal_error_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;

    logic cal_ok, cal_fail_any, retry_req;

    // Disabled channels count as calibrated and can never report a failure.
    assign cal_ok       = &(mem_cal_success | ~mem_enable_mask);
    assign cal_fail_any = |(mem_cal_fail & mem_enable_mask);

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cal_cnt_d  = cal_cnt_q;
        retry_d    = retry_q;
        retry_req  = 1'b0;

        case (state_q)
            ST_RESET_HOLD: begin
                if (npor_s_q) begin
                    if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_d    = ST_MEM_RESET;
                        deb_cnt_d  = '0;
                        hold_cnt_d = '0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            ST_MEM_RESET: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d    = ST_CAL_WAIT;
                    hold_cnt_d = '0;
                    cal_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_CAL_WAIT: begin
                if (cal_fail_any || (cal_cnt_q == CAL_W'(CAL_TIMEOUT - 1))) begin
                    retry_req = 1'b1;
                end else if (cal_ok) begin
                    state_d    = ST_KERNEL_RELEASE;
                    hold_cnt_d = '0;
                end else begin
                    cal_cnt_d = cal_cnt_q + CAL_W'(1);
                end
            end
            ST_KERNEL_RELEASE: begin
                if (!cal_ok) begin
                    retry_req = 1'b1;
                end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                    retry_d    = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!cal_ok || cal_fail_any) begin
                    state_d    = ST_MEM_RESET;
                    hold_cnt_d = '0;
                    retry_d    = (MAX_RETRIES > 0) ? RETRY_W'(1) : '0;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET_HOLD;
        endcase

        // Shared retry rule for calibration failures, timeouts and lost calibration.
        if (retry_req) begin
            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                retry_d    = retry_q + RETRY_W'(1);
                state_d    = ST_MEM_RESET;
                hold_cnt_d = '0;
            end else begin
                state_d = ST_ERROR;
            end
        end

        if (!npor_s_q) begin
            state_d    = ST_RESET_HOLD;
            retry_d    = '0;
            deb_cnt_d  = '0;
            hold_cnt_d = '0;
            cal_cnt_d  = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        mem_reset_n_d    = '0;
        kernel_reset_n_d = 1'b0;
        sys_ready_d      = 1'b0;
        cal_error_d      = 1'b0;
        hb_cnt_d         = hb_cnt_q + HB_BITS'(1);
        hb_d             = hb_q ^ (&hb_cnt_q);
        leds_d           = '0;

        case (state_d)
            ST_CAL_WAIT, ST_KERNEL_RELEASE: mem_reset_n_d = mem_enable_mask;
            ST_RUN: begin
                mem_reset_n_d    = mem_enable_mask;
                kernel_reset_n_d = 1'b1;
                sys_ready_d      = 1'b1;
            end
            ST_ERROR: cal_error_d = 1'b1;
            default:  mem_reset_n_d = '0;
        endcase

        leds_d[NUM_MEM-1:0]   = mem_cal_success & mem_enable_mask;
        leds_d[LED_WIDTH-3]   = cal_error_d;
        leds_d[LED_WIDTH-2]   = sys_ready_d;
        leds_d[LED_WIDTH-1]   = hb_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RESET_HOLD;
            npor_meta_q      <= 1'b0;
            npor_s_q         <= 1'b0;
            deb_cnt_q        <= '0;
            hold_cnt_q       <= '0;
            cal_cnt_q        <= '0;
            retry_q          <= '0;
            hb_cnt_q         <= '0;
            hb_q             <= 1'b0;
            mem_reset_n_q    <= '0;
            kernel_reset_n_q <= 1'b0;
            sys_ready_q      <= 1'b0;
            cal_error_q      <= 1'b0;
            leds_q           <= '0;
        end else begin
            state_q          <= state_d;
            npor_meta_q      <= pcie_npor;
            npor_s_q         <= npor_meta_q;
            deb_cnt_q        <= deb_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            cal_cnt_q        <= cal_cnt_d;
            retry_q          <= retry_d;
            hb_cnt_q         <= hb_cnt_d;
            hb_q             <= hb_d;
            mem_reset_n_q    <= mem_reset_n_d;
            kernel_reset_n_q <= kernel_reset_n_d;
            sys_ready_q      <= sys_ready_d;
            cal_error_q      <= cal_error_d;
            leds_q           <= leds_d;
        end
    end

    assign state          = state_q;
    assign mem_reset_n    = mem_reset_n_q;
    assign kernel_reset_n = kernel_reset_n_q;
    assign sys_ready      = sys_ready_q;
    assign cal_error      = cal_error_q;
    assign retry_count    = retry_q;
    assign leds           = leds_q;

endmodule
